// File: rtl/rv32_pkg.sv
// Shared constants, fault codes and FSM state for the RV32 load/store unit.
// Also holds the request legality check used at issue time.
package rv32_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] FLT_NONE  = 2'b00;
  localparam logic [1:0] FLT_MISAL = 2'b01;
  localparam logic [1:0] FLT_BUS   = 2'b10;
  localparam logic [1:0] FLT_ILL   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } lsu_state_e;

  // Illegal encodings take precedence over alignment.
  function automatic logic [1:0] req_check(
    input logic       wr,
    input logic [2:0] f3,
    input logic [1:0] a
  );
    logic ill;
    logic mis;
    if (wr) ill = (f3 >= 3'b011);
    else    ill = (f3 == 3'b011) || (f3 >= 3'b110);
    mis = ((f3[1:0] == 2'b01) && a[0]) ||
          ((f3[1:0] == 2'b10) && (a != 2'b00));
    if (ill)      return FLT_ILL;
    else if (mis) return FLT_MISAL;
    else          return FLT_NONE;
  endfunction

endpackage

// File: rtl/rv32_lsu_align.sv
// Load lane extraction/extension and store lane
// enables/replication for the RV32 LSU.
module rv32_lsu_align
  import rv32_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] ldata_o,
  output logic [3:0]  byteen_o,
  output logic [31:0] wrep_o
);

  logic [31:0] sh;
  logic [7:0]  b;
  logic [15:0] h;
  logic        sx;

  always_comb begin
    sh = rdata_i >> {lane_i, 3'b000};
    b  = sh[7:0];
    h  = lane_i[1] ? rdata_i[31:16]
                   : rdata_i[15:0];
    sx = ~funct3_i[2];
    ldata_o  = rdata_i;
    byteen_o = 4'hF;
    wrep_o   = wdata_i;
    unique case (funct3_i[1:0])
      2'b00: begin
        ldata_o  = {{24{sx & b[7]}}, b};
        byteen_o = 4'b0001 << lane_i;
        wrep_o   = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        ldata_o  = {{16{sx & h[15]}}, h};
        byteen_o = lane_i[1] ? 4'b1100
                             : 4'b0011;
        wrep_o   = {2{wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rv32_lsu.sv
// RV32I load/store unit: single outstanding access,
// alignment/legality faults and a bus-ready timeout.
module rv32_lsu
  import rv32_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  fault,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [3:0]  mem_byteen,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  lsu_state_e  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  fault_q, fault_d;

  logic [1:0]  chk;
  logic [31:0] ldata;
  logic [3:0]  ben;
  logic [31:0] wrep;
  logic        idle;
  logic        acc;

  rv32_lsu_align u_align (
    .funct3_i (f3_q),
    .lane_i   (addr_q[1:0]),
    .wdata_i  (wdata_q),
    .rdata_i  (mem_rdata),
    .ldata_o  (ldata),
    .byteen_o (ben),
    .wrep_o   (wrep)
  );

  assign chk = req_check(req_write, req_funct3,
                         req_addr[1:0]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    fault_d = fault_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          rdata_d = '0;
          fault_d = chk;
          if (chk != FLT_NONE) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_ACCESS;
            cnt_d   = '0;
            write_d = req_write;
            f3_d    = req_funct3;
            addr_d  = req_addr;
            wdata_d = req_wdata;
          end
        end
      end
      ST_ACCESS: begin
        cnt_d = cnt_q + 8'd1;
        // Ready on the final counted cycle still completes normally.
        if (mem_ready) begin
          state_d = ST_RESP;
          fault_d = FLT_NONE;
          rdata_d = write_q ? '0 : ldata;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_RESP;
          fault_d = FLT_BUS;
          rdata_d = '0;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      fault_q <= FLT_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
    end
  end

  assign idle = (state_q == ST_IDLE);
  assign acc  = (state_q == ST_ACCESS);

  assign stall = ~reset &
                 ((idle & req_valid) | acc);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = resp_valid ? rdata_q : '0;
  assign fault      = resp_valid ? fault_q : FLT_NONE;

  assign mem_read    = acc & ~write_q;
  assign mem_write   = acc & write_q;
  assign mem_address = acc ? {addr_q[31:2], 2'b00}
                           : '0;
  assign mem_byteen  = !acc    ? 4'h0 :
                       write_q ? ben  : 4'hF;
  assign mem_wdata   = (acc & write_q) ? wrep : '0;

endmodule

// File: tb/tb_rv32_lsu.sv
// Directed, table-driven bench for rv32_lsu
// plus hand-written reset sequences.
module tb_rv32_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  fault;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [3:0]  mem_byteen;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rv32_lsu #(.TIMEOUT(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_write   (req_write),
    .req_funct3  (req_funct3),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .stall       (stall),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .fault       (fault),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_address (mem_address),
    .mem_byteen  (mem_byteen),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready)
  );

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          dly;
    logic [1:0]  efault;
    logic [31:0] erdata;
    int          elat;
    int          eacc;
    logic [31:0] eaddr;
    logic [3:0]  eben;
    logic [31:0] ewdata;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs[NV];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h",
               name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic wr, input logic [2:0] f3,
    input logic [31:0] addr, input logic [31:0] wd,
    input logic [31:0] rd, input int dly,
    input logic [1:0] ef, input logic [31:0] er,
    input int elat, input int eacc,
    input logic [31:0] ea, input logic [3:0] eb,
    input logic [31:0] ew);
    vec_t v;
    v.wr = wr; v.f3 = f3; v.addr = addr;
    v.wdata = wd; v.rdata = rd; v.dly = dly;
    v.efault = ef; v.erdata = er;
    v.elat = elat; v.eacc = eacc;
    v.eaddr = ea; v.eben = eb; v.ewdata = ew;
    return v;
  endfunction

  task automatic run(input vec_t v, input int idx);
    int lat;
    int acc;
    logic stable;
    logic rd_seen;
    logic wr_seen;
    logic both;
    logic [31:0] a0;
    logic [31:0] w0;
    logic [3:0]  b0;
    string t;
    t = $sformatf("v%0d", idx);
    req_valid  = 1'b1;
    req_write  = v.wr;
    req_funct3 = v.f3;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    mem_rdata  = v.rdata;
    mem_ready  = (v.dly == 0);
    #1;
    chk({t, " stall_idle"}, 32'(stall), 32'd1);
    lat = 0; acc = 0; stable = 1'b1;
    rd_seen = 1'b0; wr_seen = 1'b0; both = 1'b0;
    a0 = '0; w0 = '0; b0 = '0;
    while (lat < 60) begin
      @(posedge clk); #1;
      lat++;
      if (resp_valid) break;
      if (mem_read | mem_write) begin
        acc++;
        if (acc == 1) begin
          a0 = mem_address;
          b0 = mem_byteen;
          w0 = mem_wdata;
        end else if (mem_address !== a0 ||
                     mem_byteen !== b0 ||
                     mem_wdata !== w0) begin
          stable = 1'b0;
        end
        if (mem_read & mem_write) both = 1'b1;
        if (!stall) stable = 1'b0;
        rd_seen |= mem_read;
        wr_seen |= mem_write;
        mem_ready = (acc > v.dly);
      end
    end
    chk({t, " resp_valid"}, 32'(resp_valid), 32'd1);
    chk({t, " latency"}, 32'(lat), 32'(v.elat));
    chk({t, " fault"}, 32'(fault), 32'(v.efault));
    chk({t, " rdata"}, resp_rdata, v.erdata);
    chk({t, " stall_resp"}, 32'(stall), 32'd0);
    chk({t, " access_cycles"}, 32'(acc),
        32'(v.eacc));
    if (v.eacc > 0) begin
      chk({t, " address"}, a0, v.eaddr);
      chk({t, " byteen"}, 32'(b0), 32'(v.eben));
      chk({t, " wdata"}, w0, v.ewdata);
      chk({t, " strobe_kind"},
          32'({rd_seen, wr_seen}),
          32'({~v.wr, v.wr}));
      chk({t, " held_stable"},
          32'(stable & ~both), 32'd1);
    end
    req_valid = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    chk({t, " resp_one_cycle"},
        32'(resp_valid), 32'd0);
  endtask

  initial begin
    vecs[0]  = mk(0, 3'b000, 32'h103, 0, 32'h80AABBCC, 0,
                  2'b00, 32'hFFFFFF80, 2, 1,
                  32'h100, 4'hF, 0);
    vecs[1]  = mk(1, 3'b001, 32'h202, 32'h1234ABCD, 0, 3,
                  2'b00, 0, 5, 4,
                  32'h200, 4'b1100, 32'hABCDABCD);
    vecs[2]  = mk(0, 3'b010, 32'h101, 0, 0, 0,
                  2'b01, 0, 1, 0, 0, 0, 0);
    vecs[3]  = mk(0, 3'b101, 32'h10, 0, 32'hDEADBEEF, 255,
                  2'b10, 0, 17, 16, 32'h10, 4'hF, 0);
    vecs[4]  = mk(0, 3'b011, 32'h0, 0, 0, 0,
                  2'b11, 0, 1, 0, 0, 0, 0);
    vecs[5]  = mk(0, 3'b001, 32'h102, 0, 32'h80017FFF, 1,
                  2'b00, 32'hFFFF8001, 3, 2,
                  32'h100, 4'hF, 0);
    vecs[6]  = mk(0, 3'b100, 32'h101, 0, 32'h1234F078, 0,
                  2'b00, 32'h000000F0, 2, 1,
                  32'h100, 4'hF, 0);
    vecs[7]  = mk(0, 3'b010, 32'h204, 0, 32'hCAFEBABE, 2,
                  2'b00, 32'hCAFEBABE, 4, 3,
                  32'h204, 4'hF, 0);
    vecs[8]  = mk(1, 3'b000, 32'h301, 32'h000000A5, 0, 0,
                  2'b00, 0, 2, 1,
                  32'h300, 4'b0010, 32'hA5A5A5A5);
    vecs[9]  = mk(1, 3'b010, 32'h400, 32'h11223344, 0, 0,
                  2'b00, 0, 2, 1,
                  32'h400, 4'hF, 32'h11223344);
    vecs[10] = mk(1, 3'b001, 32'h203, 32'h5555, 0, 0,
                  2'b01, 0, 1, 0, 0, 0, 0);
    vecs[11] = mk(1, 3'b011, 32'h200, 32'h5555, 0, 0,
                  2'b11, 0, 1, 0, 0, 0, 0);
    vecs[12] = mk(0, 3'b000, 32'h100, 0, 32'h0000007F, 15,
                  2'b00, 32'h0000007F, 17, 16,
                  32'h100, 4'hF, 0);
    vecs[13] = mk(0, 3'b001, 32'h100, 0, 32'h00008000, 0,
                  2'b00, 32'hFFFF8000, 2, 1,
                  32'h100, 4'hF, 0);
    vecs[14] = mk(0, 3'b111, 32'h100, 0, 0, 0,
                  2'b11, 0, 1, 0, 0, 0, 0);

    reset = 1'b1;
    req_valid = 1'b1; req_write = 1'b1;
    req_funct3 = 3'b010; req_addr = 32'h40;
    req_wdata = 32'hFFFFFFFF;
    mem_rdata = '0; mem_ready = 1'b1;
    #12;
    chk("rst stall", 32'(stall), 0);
    chk("rst resp_valid", 32'(resp_valid), 0);
    chk("rst rdata", resp_rdata, 0);
    chk("rst fault", 32'(fault), 0);
    chk("rst strobes",
        32'({mem_read, mem_write}), 0);
    chk("rst address", mem_address, 0);
    chk("rst byteen", 32'(mem_byteen), 0);
    chk("rst wdata", mem_wdata, 0);
    req_valid = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) run(vecs[i], i);

    req_valid = 1'b1; req_write = 1'b0;
    req_funct3 = 3'b010; req_addr = 32'h500;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid pre_read", 32'(mem_read), 1);
    reset = 1'b1;
    #1;
    chk("mid rst strobes",
        32'({mem_read, mem_write}), 0);
    chk("mid rst stall", 32'(stall), 0);
    chk("mid rst address", mem_address, 0);
    req_valid = 1'b0;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    begin
      int seen;
      seen = 0;
      for (int k = 0; k < 6; k++) begin
        @(posedge clk); #1;
        if (resp_valid | mem_read) seen++;
      end
      chk("mid rst no_resp", 32'(seen), 0);
    end
    mem_ready = 1'b0;
    run(vecs[0], 100);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rv32_lsu.md
RV32_LSU -- requirements
Module: rv32_lsu

Interface
REQ-001 Parameter: TIMEOUT, 16, maximum ACCESS cycles waited for mem_ready before bus fault (legal range 1..255).
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  1  core presents a load/store this cycle.
REQ-005 req_write  input  1  1 = store, 0 = load.
REQ-006 req_funct3  input  3  RV32I width/sign code (LB/LH/LW/LBU/LHU; SB/SH/SW).
REQ-007 req_addr  input  32  byte address.
REQ-008 req_wdata  input  32  store data (rs2).
REQ-009 stall  output  1  core holds PC/request while high.
REQ-010 resp_valid  output  1  one-cycle completion pulse.
REQ-011 resp_rdata  output  32  aligned, extended load result.
REQ-012 fault  output  2  00 none, 01 misaligned, 10 bus timeout, 11 illegal funct3; valid with resp_valid.
REQ-013 mem_read / mem_write  output  1 each  bus request strobes.
REQ-014 mem_address  output  32  word address, req_addr with [1:0] = 00.
REQ-015 mem_byteen  output  4  byte lanes for stores; 1111 for loads.
REQ-016 mem_wdata  output  32  lane-replicated store data.
REQ-017 mem_rdata  input  32  read data, sampled when mem_ready high.
REQ-018 mem_ready  input  1  bus completes the current access.

Function
REQ-019 The FSM SHALL have states IDLE, ACCESS, RESP.
REQ-020 IDLE + req_valid: legal -> latch request, go ACCESS next cycle; misaligned or illegal funct3 -> go RESP with fault set, no bus strobe ever.
REQ-021 Misaligned: H/HU/SH with addr[0]=1; W/SW with addr[1:0]!=0. Illegal funct3: loads 011/110/111; stores 011..111.
REQ-022 ACCESS: exactly one of mem_read/mem_write high; address/byteen/wdata held stable until mem_ready.
REQ-023 ACCESS + mem_ready: capture extracted load data, go RESP (min latency req_valid -> resp_valid = 2 cycles with mem_ready already high).
REQ-024 A timeout counter SHALL clear on ACCESS entry and increment each ACCESS cycle; reaching TIMEOUT without mem_ready -> RESP, fault=10, resp_rdata=0, strobes dropped.
REQ-025 mem_ready in the same cycle the counter reaches TIMEOUT SHALL win (normal completion).
REQ-026 RESP: resp_valid=1 for exactly one cycle, then IDLE; req_valid ignored in RESP.
REQ-027 stall = (IDLE & req_valid) | ACCESS; low in RESP.
REQ-028 Loads: lane = addr[1:0] (byte) or addr[1] (half); LB/LH sign-extend, LBU/LHU zero-extend, LW passthrough.
REQ-029 Stores: SB byteen = 0001<<addr[1:0], data byte replicated x4; SH byteen = 0011<<(2*addr[1]), half replicated x2; SW 1111.
REQ-030 resp_rdata SHALL be 0 for stores and faults; mem_ready outside ACCESS ignored.

Reset
REQ-031 reset SHALL force IDLE, counter 0, all outputs 0 (stall, resp_valid, resp_rdata, fault, strobes, address, byteen, wdata) immediately.
REQ-032 reset during ACCESS SHALL drop strobes the same cycle, no resp_valid afterwards.

Structure
REQ-033 rv32_pkg SHALL hold funct3 constants, fault codes and the FSM state enum.
REQ-034 Lane align/extend and byteen/replication logic SHALL be a combinational sub-module rv32_lsu_align.

Verification
REQ-035 LB addr 0x103, mem_rdata 0x80AABBCC, ready immediate -> resp_rdata 0xFFFFFF80, fault 00, 2-cycle latency.
REQ-036 SH addr 0x202, wdata 0x1234ABCD -> mem_address 0x200, byteen 1100, mem_wdata 0xABCDABCD, write held through 3 ready-low cycles.
REQ-037 LW addr 0x101 -> no mem_read ever, resp_valid next cycle, fault 01.
REQ-038 LHU addr 0x10, mem_ready never, TIMEOUT=16 -> resp_valid after 16 ACCESS cycles, fault 10, rdata 0.
REQ-039 funct3 011 load -> fault 11; reset asserted mid-ACCESS -> strobes 0 immediately, IDLE, no resp_valid.
